// File: rtl/dpram_be_wr_arb_pkg.sv
// Shared types and default geometry for the byte-enabled write arbiter.
package dpram_pkg;

   localparam int DW_DEF = 32;   // RAM word width in bits
   localparam int AW_DEF = 6;    // RAM address width (64 words)

   // IDLE: arbitrate, WR: full-word write, RD: fetch old word, MRG: merged write
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      MRG  = 2'd3
   } state_t;

endpackage

// File: rtl/dpram_be_wr_arb_if.sv
// Two-port write request bundle: valid/ready handshake with addr, data, byte enables.
interface dpram_be_wr_arb_if
   import dpram_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NBE = DW / 8
) ();

   logic           req_a_valid;
   logic           req_a_ready;
   logic [AW-1:0]  req_a_addr;
   logic [DW-1:0]  req_a_data;
   logic [NBE-1:0] req_a_be;

   logic           req_b_valid;
   logic           req_b_ready;
   logic [AW-1:0]  req_b_addr;
   logic [DW-1:0]  req_b_data;
   logic [NBE-1:0] req_b_be;

   // Requester side
   modport master (
      output req_a_valid, req_a_addr, req_a_data, req_a_be,
      input  req_a_ready,
      output req_b_valid, req_b_addr, req_b_data, req_b_be,
      input  req_b_ready
   );

   // Arbiter side
   modport slave (
      input  req_a_valid, req_a_addr, req_a_data, req_a_be,
      output req_a_ready,
      input  req_b_valid, req_b_addr, req_b_data, req_b_be,
      output req_b_ready
   );

endinterface

// File: rtl/dpram_be_wr_arb_be_merge.sv
// Byte-lane merge: enabled lanes come from the new data, the rest keep the old word.
module be_merge #(
   parameter int NBE = 4
) (
   input  logic [8*NBE-1:0] new_data,
   input  logic [8*NBE-1:0] old_data,
   input  logic [NBE-1:0]   be,
   output logic [8*NBE-1:0] merged
);

   // Per-lane select between new and old bytes
   always_comb begin
      merged = old_data;
      for (int i = 0; i < NBE; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dpram_be_wr_arb.sv
// Serializes byte-enabled writes from two ports into full-word RAM writes.
// Partial writes become read-modify-write (RD then MRG); full writes go straight to WR.
// DW must be a multiple of 8.
module dpram_be_wr_arb
   import dpram_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NBE = DW / 8
) (
   input  logic           clk,
   input  logic           rst,
   dpram_be_wr_arb_if.slave req,
   output logic           ram_we,
   output logic [AW-1:0]  ram_addr_wr,
   output logic [DW-1:0]  ram_data_wr,
   output logic [AW-1:0]  ram_addr_rd,
   input  logic [DW-1:0]  ram_q,
   output logic           busy,
   output logic [15:0]    wr_cnt
);

   state_t         state_p0;
   state_t         state_nxt;
   logic           last_b_p0;      // 1 when port B was granted most recently
   logic [AW-1:0]  addr_p0;
   logic [AW-1:0]  rd_addr_p0;
   logic [DW-1:0]  data_p0;
   logic [NBE-1:0] be_p0;
   logic [15:0]    cnt_p0;

   logic           grant_a;
   logic           grant_b;
   logic           accept;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_data;
   logic [NBE-1:0] sel_be;
   logic           sel_full;
   logic           sel_partial;
   logic [DW-1:0]  merged;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Round-robin grant: only in IDLE and never under reset; ties go to the port not granted last
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst && (state_p0 == IDLE)) begin
         if (req.req_a_valid && (!req.req_b_valid || last_b_p0)) begin
            grant_a = 1'b1;
         end else if (req.req_b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign req.req_a_ready = grant_a;
   assign req.req_b_ready = grant_b;
   assign accept          = grant_a | grant_b;

   // Select the granted request's payload
   always_comb begin
      sel_addr = req.req_a_addr;
      sel_data = req.req_a_data;
      sel_be   = req.req_a_be;
      if (grant_b) begin
         sel_addr = req.req_b_addr;
         sel_data = req.req_b_data;
         sel_be   = req.req_b_be;
      end
   end

   assign sel_full    = &sel_be;
   assign sel_partial = (|sel_be) && !sel_full;

   // Next-state decode: empty byte enables are accepted and dropped
   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         IDLE: begin
            if (accept) begin
               if (sel_full) begin
                  state_nxt = WR;
               end else if (sel_partial) begin
                  state_nxt = RD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         WR:      state_nxt = IDLE;
         RD:      state_nxt = MRG;
         MRG:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= IDLE;
      end else begin
         state_p0 <= state_nxt;
      end
   end

   // Round-robin pointer, reset so that A wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b_p0 <= 1'b1;
      end else if (grant_a) begin
         last_b_p0 <= 1'b0;
      end else if (grant_b) begin
         last_b_p0 <= 1'b1;
      end
   end

   // Latch write payload on acceptance; only meaningful while busy, so no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         data_p0 <= sel_data;
         be_p0   <= sel_be;
      end
   end

   // Latch write address and RAM read address; read address only moves for partial writes
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_p0    <= '0;
         rd_addr_p0 <= '0;
      end else if (accept) begin
         addr_p0 <= sel_addr;
         if (sel_partial) begin
            rd_addr_p0 <= sel_addr;
         end
      end
   end

   // Saturating count of RAM write cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0 <= '0;
      end else if (ram_we) begin
         cnt_p0 <= sat_inc16(cnt_p0);
      end
   end

   be_merge #(
      .NBE (NBE)
   ) u_be_merge (
      .new_data (data_p0),
      .old_data (ram_q),
      .be       (be_p0),
      .merged   (merged)
   );

   // RAM write data: latched word for WR, merged word for MRG, zero otherwise
   always_comb begin
      ram_data_wr = '0;
      case (state_p0)
         WR:      ram_data_wr = data_p0;
         MRG:     ram_data_wr = merged;
         default: ram_data_wr = '0;
      endcase
   end

   assign ram_we      = (state_p0 == WR) || (state_p0 == MRG);
   assign ram_addr_wr = addr_p0;
   assign ram_addr_rd = rd_addr_p0;
   assign busy        = (state_p0 != IDLE);
   assign wr_cnt      = cnt_p0;

endmodule

// File: tb/tb_dpram_be_wr_arb.sv
// Directed bench for dpram_be_wr_arb with a registered-read RAM model.
module tb_dpram_be_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_we;
   logic [5:0]  ram_addr_wr;
   logic [31:0] ram_data_wr;
   logic [5:0]  ram_addr_rd;
   logic [31:0] ram_q;
   logic        busy;
   logic [15:0] wr_cnt;

   logic [31:0] mem [64];
   logic        pl_en;
   logic [5:0]  pl_addr;
   logic [31:0] pl_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dpram_be_wr_arb_if #(.DW(32), .AW(6), .NBE(4)) ifc ();

   dpram_be_wr_arb #(.DW(32), .AW(6), .NBE(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (ifc),
      .ram_we      (ram_we),
      .ram_addr_wr (ram_addr_wr),
      .ram_data_wr (ram_data_wr),
      .ram_addr_rd (ram_addr_rd),
      .ram_q       (ram_q),
      .busy        (busy),
      .wr_cnt      (wr_cnt)
   );

   // RAM model: full-word write, one-cycle registered read, bench preload port
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr_wr] <= ram_data_wr;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end
      ram_q <= mem[ram_addr_rd];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_a(input logic v, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
      ifc.req_a_valid = v;
      ifc.req_a_addr  = a;
      ifc.req_a_data  = d;
      ifc.req_a_be    = b;
   endtask

   task automatic set_b(input logic v, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
      ifc.req_b_valid = v;
      ifc.req_b_addr  = a;
      ifc.req_b_data  = d;
      ifc.req_b_be    = b;
   endtask

   task automatic clr();
      set_a(1'b0, 6'd0, 32'h0, 4'h0);
      set_b(1'b0, 6'd0, 32'h0, 4'h0);
   endtask

   initial begin
      rst     = 1'b1;
      pl_en   = 1'b0;
      pl_addr = 6'd0;
      pl_data = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      clr();
      set_a(1'b1, 6'd3, 32'h1, 4'hF);
      set_b(1'b1, 6'd4, 32'h2, 4'hF);

      // Reset state, readies held low under reset
      @(negedge clk);
      @(negedge clk); #1;
      chk("rst_ready_a", 32'(ifc.req_a_ready), 32'h0);
      chk("rst_ready_b", 32'(ifc.req_b_ready), 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cnt", 32'(wr_cnt), 32'h0);
      chk("rst_addr_wr", 32'(ram_addr_wr), 32'h0);
      chk("rst_addr_rd", 32'(ram_addr_rd), 32'h0);
      chk("rst_data_wr", ram_data_wr, 32'h0);

      // Single full write on A
      @(negedge clk); rst = 1'b0; clr(); set_a(1'b1, 6'd5, 32'hDEADBEEF, 4'hF); #1;
      chk("t1_ready_a", 32'(ifc.req_a_ready), 32'h1);
      chk("t1_ready_b", 32'(ifc.req_b_ready), 32'h0);
      @(negedge clk); clr(); #1;
      chk("t1_we", 32'(ram_we), 32'h1);
      chk("t1_addr_wr", 32'(ram_addr_wr), 32'h5);
      chk("t1_data_wr", ram_data_wr, 32'hDEADBEEF);
      chk("t1_busy", 32'(busy), 32'h1);
      @(negedge clk); #1;
      chk("t1_we_off", 32'(ram_we), 32'h0);
      chk("t1_cnt", 32'(wr_cnt), 32'h1);
      chk("t1_mem", mem[5], 32'hDEADBEEF);

      // Partial write read-modify-write
      @(negedge clk); pl_en = 1'b1; pl_addr = 6'd5; pl_data = 32'h11223344;
      @(negedge clk); pl_en = 1'b0; set_a(1'b1, 6'd5, 32'hAABBCCDD, 4'b0101); #1;
      chk("t2_ready_a", 32'(ifc.req_a_ready), 32'h1);
      @(negedge clk); clr(); #1;
      chk("t2_rd_we", 32'(ram_we), 32'h0);
      chk("t2_rd_addr", 32'(ram_addr_rd), 32'h5);
      chk("t2_rd_busy", 32'(busy), 32'h1);
      @(negedge clk); #1;
      chk("t2_mrg_we", 32'(ram_we), 32'h1);
      chk("t2_mrg_data", ram_data_wr, 32'h11BB33DD);
      chk("t2_mrg_addr", 32'(ram_addr_wr), 32'h5);
      @(negedge clk); #1;
      chk("t2_mem", mem[5], 32'h11BB33DD);
      chk("t2_cnt", 32'(wr_cnt), 32'h2);

      // Round-robin from reset with both ports held valid
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      set_a(1'b1, 6'd10, 32'hA0A0A0A0, 4'hF);
      set_b(1'b1, 6'd11, 32'hB0B0B0B0, 4'hF);
      #1;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) begin
            @(negedge clk); #1;
         end
         if ((k % 2) == 0) begin
            chk($sformatf("t3_rdy_a_%0d", k), 32'(ifc.req_a_ready), ((k % 4) == 0) ? 32'h1 : 32'h0);
            chk($sformatf("t3_rdy_b_%0d", k), 32'(ifc.req_b_ready), ((k % 4) == 2) ? 32'h1 : 32'h0);
         end else begin
            chk($sformatf("t3_we_%0d", k), 32'(ram_we), 32'h1);
            chk($sformatf("t3_addr_%0d", k), 32'(ram_addr_wr), ((k % 4) == 1) ? 32'd10 : 32'd11);
         end
      end
      @(negedge clk); clr(); #1;
      chk("t3_cnt", 32'(wr_cnt), 32'h4);
      chk("t3_mem_a", mem[10], 32'hA0A0A0A0);
      chk("t3_mem_b", mem[11], 32'hB0B0B0B0);

      // Empty byte enables: accepted, no RAM write
      @(negedge clk); set_a(1'b1, 6'd20, 32'hCAFEF00D, 4'h0); #1;
      chk("t4_ready_a", 32'(ifc.req_a_ready), 32'h1);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk); clr(); #1;
         chk($sformatf("t4_we_%0d", j), 32'(ram_we), 32'h0);
         chk($sformatf("t4_cnt_%0d", j), 32'(wr_cnt), 32'h4);
      end
      @(negedge clk); set_a(1'b1, 6'd21, 32'h55555555, 4'h0); #1;
      chk("t4b_ready_a", 32'(ifc.req_a_ready), 32'h1);
      @(negedge clk); clr(); set_b(1'b1, 6'd22, 32'h12345678, 4'hF); #1;
      chk("t4b_ready_b", 32'(ifc.req_b_ready), 32'h1);
      chk("t4b_we0", 32'(ram_we), 32'h0);
      @(negedge clk); clr(); #1;
      chk("t4b_we1", 32'(ram_we), 32'h1);
      chk("t4b_addr", 32'(ram_addr_wr), 32'd22);
      @(negedge clk); #1;
      chk("t4b_cnt", 32'(wr_cnt), 32'h5);
      chk("t4b_mem", mem[22], 32'h12345678);
      chk("t4b_mem20", mem[20], 32'h0);

      // Full write followed immediately by a partial write to the same word
      @(negedge clk); set_a(1'b1, 6'd9, 32'hFFFFFFFF, 4'hF); #1;
      chk("t5_rdy0", 32'(ifc.req_a_ready), 32'h1);
      @(negedge clk); set_a(1'b1, 6'd9, 32'h00000000, 4'b0001); #1;
      chk("t5_rdy1", 32'(ifc.req_a_ready), 32'h0);
      chk("t5_we1", 32'(ram_we), 32'h1);
      @(negedge clk); #1;
      chk("t5_rdy2", 32'(ifc.req_a_ready), 32'h1);
      @(negedge clk); clr(); #1;
      chk("t5_rd_addr", 32'(ram_addr_rd), 32'd9);
      @(negedge clk); #1;
      chk("t5_mrg_we", 32'(ram_we), 32'h1);
      chk("t5_mrg_data", ram_data_wr, 32'hFFFFFF00);
      @(negedge clk); #1;
      chk("t5_mem", mem[9], 32'hFFFFFF00);
      chk("t5_cnt", 32'(wr_cnt), 32'h7);

      // Reset during MRG aborts; A wins the next tie even though A was granted last
      @(negedge clk); pl_en = 1'b1; pl_addr = 6'd30; pl_data = 32'h01020304;
      @(negedge clk); pl_en = 1'b0; set_a(1'b1, 6'd30, 32'hAABBCCDD, 4'b0011); #1;
      chk("t6_ready_a", 32'(ifc.req_a_ready), 32'h1);
      @(negedge clk); clr(); #1;
      chk("t6_rd_addr", 32'(ram_addr_rd), 32'd30);
      @(negedge clk); rst = 1'b1;
      set_a(1'b1, 6'd1, 32'h0A0A0A0A, 4'hF);
      set_b(1'b1, 6'd2, 32'h0B0B0B0B, 4'hF);
      #1;
      chk("t6_mrg_we", 32'(ram_we), 32'h1);
      chk("t6_mrg_rdy_a", 32'(ifc.req_a_ready), 32'h0);
      @(negedge clk); #1;
      chk("t6_we", 32'(ram_we), 32'h0);
      chk("t6_busy", 32'(busy), 32'h0);
      chk("t6_cnt", 32'(wr_cnt), 32'h0);
      chk("t6_addr_wr", 32'(ram_addr_wr), 32'h0);
      chk("t6_addr_rd", 32'(ram_addr_rd), 32'h0);
      chk("t6_data_wr", ram_data_wr, 32'h0);
      chk("t6_rst_rdy_a", 32'(ifc.req_a_ready), 32'h0);
      chk("t6_rst_rdy_b", 32'(ifc.req_b_ready), 32'h0);
      @(negedge clk); rst = 1'b0; #1;
      chk("t6_tie_a", 32'(ifc.req_a_ready), 32'h1);
      chk("t6_tie_b", 32'(ifc.req_b_ready), 32'h0);
      @(negedge clk); clr(); #1;
      chk("t6_we_after", 32'(ram_we), 32'h1);
      chk("t6_addr_after", 32'(ram_addr_wr), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
